// File: rtl/sng_stream.sv
// Multi-channel stochastic number generator.
// One shared maximal-length Fibonacci LFSR feeds every channel. Each channel compares its own
// rotation of the LFSR state against a probability word that is latched at stream start.
// A start/done handshake frames a stream of programmable length (0 selects the full period).
module sng_stream #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             seed,
  input  logic [CHANNELS*WIDTH-1:0]    prob,
  input  logic [WIDTH-1:0]             len,
  input  logic                         start,
  input  logic                         en,
  output logic [CHANNELS-1:0]          bit_out,
  output logic                         bit_valid,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             lfsr_state
);

  // Tap masks: tap k sets mask bit k-1.
  function automatic logic [15:0] tap_table(int unsigned w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

  localparam logic [15:0]      TapsAll = tap_table(WIDTH);
  localparam logic [WIDTH-1:0] Taps    = TapsAll[WIDTH-1:0];

  typedef enum logic {StIdle, StRun} state_e;

  state_e                      state_q, state_d;
  logic [WIDTH-1:0]            lfsr_q, lfsr_d;
  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0]   prob_q, prob_d;
  logic [CHANNELS-1:0]         bit_q, bit_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;

  logic [WIDTH-1:0]            seed_fix;
  logic [WIDTH-1:0]            lfsr_next;
  logic [CHANNELS-1:0]         chan_bits;
  logic [2*WIDTH-1:0]          dbl;
  logic [WIDTH-1:0]            rot;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_fix  = (seed == '0) ? WIDTH'(1) : seed;
  assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & Taps)};

  // Per-channel comparison of the rotated LFSR state against the latched probability.
  always_comb begin
    chan_bits = '0;
    dbl       = '0;
    rot       = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      dbl          = {lfsr_q, lfsr_q} << c;
      rot          = dbl[2*WIDTH-1 -: WIDTH];
      chan_bits[c] = (rot <= prob_q[c*WIDTH +: WIDTH]);
    end
  end

  // Next-state logic for the stream FSM, LFSR, counter and output registers.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    prob_d  = prob_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          lfsr_d  = seed_fix;
          prob_d  = prob;
          cnt_d   = (len == '0) ? '1 : len;
          state_d = StRun;
        end
      end
      StRun: begin
        if (en) begin
          bit_d   = chan_bits;
          valid_d = 1'b1;
          lfsr_d  = lfsr_next;
          cnt_d   = cnt_q - WIDTH'(1);
          if (cnt_q == WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset reloads the LFSR with the (sanitised) seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lfsr_q  <= seed_fix;
      cnt_q   <= '0;
      prob_q  <= '0;
      bit_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      prob_q  <= prob_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = valid_q;
  assign done       = done_q;
  assign busy       = (state_q == StRun);
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_sng_stream.sv
// Self-checking bench for sng_stream (WIDTH=8, CHANNELS=2).
// A queue of expected bits is built from the LFSR/rotation/compare rules at each start and is
// checked on every bit_valid cycle; literal expectations pin counts and known states.
module tb_sng_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  seed = 8'hA5;
  logic [15:0] prob = '0;
  logic [7:0]  len = '0;
  logic        start = 1'b0;
  logic        en = 1'b1;
  logic [1:0]  bit_out;
  logic        bit_valid;
  logic        busy;
  logic        done;
  logic [7:0]  lfsr_state;

  sng_stream #(.WIDTH(8), .CHANNELS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed       (seed),
    .prob       (prob),
    .len        (len),
    .start      (start),
    .en         (en),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] bits;
    logic [7:0] nxt;
    bit         last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_valid = 0;
  int         ones0 = 0;
  int         ones1 = 0;
  bit [255:0] seen = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Taps 8,6,5,4: feedback into bit 1, register shifts left.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] s, input int c);
    if (c == 0) return s;
    return 8'((s << c) | (s >> (8 - c)));
  endfunction

  task automatic push_stream(input logic [7:0] sd, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] ln);
    logic [7:0] s;
    int         n;
    exp_t       e;
    s = (sd == 8'd0) ? 8'd1 : sd;
    n = (ln == 8'd0) ? 255 : int'(ln);
    for (int i = 0; i < n; i++) begin
      e.bits[0] = (rotl(s, 0) <= p0);
      e.bits[1] = (rotl(s, 1) <= p1);
      e.nxt     = lfsr_step(s);
      e.last    = (i == n - 1);
      exp_q.push_back(e);
      s = e.nxt;
    end
  endtask

  // Compare process: every bit_valid cycle is checked against the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got bit_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          cur = exp_q.pop_front();
          check("bit_out", 32'(bit_out), 32'(cur.bits));
          check("lfsr_after_bit", 32'(lfsr_state), 32'(cur.nxt));
          check("done_on_last", 32'(done), 32'(cur.last));
          check("busy_during_bit", 32'(busy), 32'(!cur.last));
        end
        n_valid++;
        ones0 += int'(bit_out[0]);
        ones1 += int'(bit_out[1]);
        seen[lfsr_state] = 1'b1;
      end else begin
        check("done_without_valid", 32'(done), 32'd0);
      end
    end
  end

  task automatic clear_stats();
    n_valid = 0;
    ones0   = 0;
    ones1   = 0;
    seen    = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic start_stream(input logic [7:0] sd, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] ln);
    seed  = sd;
    prob  = {p1, p0};
    len   = ln;
    start = 1'b1;
    push_stream(sd, p0, p1, ln);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns at posedge+1 of the cycle in which done is high.
  task automatic wait_done(input int budget, input bit stall);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      if (stall) en = (k % 3 == 0);
      @(posedge clk);
      #1;
      k++;
    end
    en = 1'b1;
    if (done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, including zero-seed substitution while held in reset.
    #2 reset = 1'b1;
    #1;
    check("rst_lfsr", 32'(lfsr_state), 32'hA5);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    check("rst_valid", 32'(bit_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    seed = 8'h00;
    @(posedge clk);
    #1;
    check("rst_zero_seed", 32'(lfsr_state), 32'h01);
    seed = 8'hA5;
    @(posedge clk);
    #1;
    check("rst_seed_a5", 32'(lfsr_state), 32'hA5);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full period, prob 128 on both channels.
    clear_stats();
    start_stream(8'hA5, 8'd128, 8'd128, 8'd0);
    check("fp_busy", 32'(busy), 32'd1);
    check("fp_first_state", 32'(lfsr_state), 32'hA5);
    @(posedge clk);
    #1;
    check("fp_second_state", 32'(lfsr_state), 32'h4A);
    check("fp_first_bits", 32'(bit_out), 32'h2);
    wait_done(600, 1'b0);
    settle();
    check("fp_count", n_valid, 255);
    check("fp_ones0", ones0, 128);
    check("fp_ones1", ones1, 128);
    check("fp_lfsr_return", 32'(lfsr_state), 32'hA5);
    check("fp_distinct", $countones(seen), 255);
    check("fp_busy_after", 32'(busy), 32'd0);

    // Probability extremes.
    clear_stats();
    start_stream(8'h77, 8'd0, 8'd255, 8'd0);
    wait_done(600, 1'b0);
    settle();
    check("ext_ones0", ones0, 0);
    check("ext_ones1", ones1, 255);

    // Zero seed stream.
    clear_stats();
    start_stream(8'h00, 8'd200, 8'd200, 8'd0);
    wait_done(600, 1'b0);
    settle();
    check("zs_count", n_valid, 255);
    check("zs_ones0", ones0, 200);
    check("zs_ones1", ones1, 200);

    // Short stream with stalls.
    clear_stats();
    start_stream(8'h3C, 8'd90, 8'd170, 8'd10);
    wait_done(200, 1'b1);
    settle();
    check("stall_count", n_valid, 10);

    // Reset mid-stream at bit 37, then rerun the same stream.
    clear_stats();
    start_stream(8'h3C, 8'd90, 8'd170, 8'd0);
    for (int k = 0; k < 200 && n_valid < 37; k++) begin
      @(negedge clk);
      #1;
    end
    check("mid_reached_37", n_valid, 37);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_bit_out", 32'(bit_out), 32'd0);
    check("mid_valid", 32'(bit_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_lfsr", 32'(lfsr_state), 32'h3C);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
    start_stream(8'h3C, 8'd90, 8'd170, 8'd0);
    wait_done(600, 1'b0);
    settle();
    check("mid_rerun_count", n_valid, 255);

    // Start ignored in RUN, then back-to-back start in the done cycle.
    clear_stats();
    start_stream(8'h5A, 8'd100, 8'd60, 8'd20);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    seed  = 8'h11;
    prob  = {8'd7, 8'd7};
    len   = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200, 1'b0);
    start_stream(8'hC3, 8'd30, 8'd220, 8'd5);
    check("b2b_gap", 32'(bit_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("ign_count", n_valid, 20);
    clear_stats();
    wait_done(100, 1'b0);
    settle();
    check("b2b_count", n_valid, 5);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sng_stream.md
# sng_stream

Parametrised multi-channel stochastic number generator. A shared maximal-length Fibonacci LFSR of WIDTH bits produces a pseudo-random sequence. Each channel compares a channel-specific rotation of the LFSR state against a latched probability word and emits one stochastic bit per cycle. A start/done handshake frames a stream of programmable length. The block sits in front of the stochastic arithmetic units and replaces the fixed 8-bit single-stream generator.

## Interface
- WIDTH, 8, LFSR/probability width; supported 4..16
- CHANNELS, 2, number of independent output bitstreams; supported 1..WIDTH

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- seed  in  WIDTH  LFSR initial value; value 0 is replaced by 1
- prob  in  CHANNELS*WIDTH  probability word per channel; channel c at [c*WIDTH +: WIDTH]
- len  in  WIDTH  stream length in bits; 0 means full period 2^WIDTH-1
- start  in  1  begin a stream; sampled only in IDLE
- en  in  1  advance enable; low stalls a running stream
- bit_out  out  CHANNELS  stochastic bits, one per channel
- bit_valid  out  1  bit_out carries a stream bit this cycle
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse coincident with the last bit_valid
- lfsr_state  out  WIDTH  current LFSR register, for debug/sharing

## Operation
- **LFSR:** bits numbered 1..WIDTH (bit k = lfsr[k-1]). The register shifts left and the feedback enters bit 1. Feedback is the XOR of the tap bits.
- **Taps per WIDTH:**
  - 4: 4,3
  - 5: 5,3
  - 6: 6,5
  - 7: 7,6
  - 8: 8,6,5,4
  - 9: 9,5
  - 10: 10,7
  - 11: 11,9
  - 12: 12,6,4,1
  - 13: 13,4,3,1
  - 14: 14,5,3,1
  - 15: 15,14
  - 16: 16,15,13,4
- **Period:** exactly 2^WIDTH-1 over all nonzero states.
- **Zero seed:** seed' = (seed==0) ? 1 : seed. The LFSR never holds 0.
- **Channel c value:** r_c = lfsr rotated left by c bits; channel 0 is unrotated. The bit is r_c <= prob_c, unsigned compare.
  - Rotation is a bijection on nonzero values, so over a full period each channel emits exactly prob_c ones.
- **FSM IDLE:**
  - busy=0 and the LFSR holds.
  - On start: lfsr <= seed'; prob is latched into internal registers; the counter is loaded with len (0 → 2^WIDTH-1); go to RUN.
- **FSM RUN, en=1:**
  - Register bit_out from the current state and latched prob; bit_valid <= 1.
  - Advance the LFSR and decrement the counter.
  - If counter==1: done <= 1 and go to IDLE.
- **FSM RUN, en=0:**
  - The LFSR, counter and latched prob hold; bit_valid <= 0; done <= 0.
- start in RUN is ignored. prob/len/seed changes in RUN have no effect.
- **Reset (any time, including mid-stream):**
  - Immediately: state IDLE; lfsr = seed'; bit_out=0, bit_valid=0, busy=0, done=0; counter=0; latched prob=0.
- After done, the LFSR holds its final value until the next start reloads seed'.

## Timing
- start sampled at edge E0. busy=1 after E0, through the edge that asserts done.
- First bit_valid (from state seed') is after edge E1, provided en=1 at E1. Nth bit is after the Nth enabled RUN edge.
- done and the final bit_valid are high in the same cycle. busy drops at the same edge that raises done.
- The next start can be sampled in the cycle done is high, giving a back-to-back stream with a one-cycle bit_valid gap.
- Stall latency: en low at edge Ek gives bit_valid low after Ek. Resuming continues the sequence with no skipped or repeated state.
- lfsr_state is the register itself: zero latency.

## Test plan
- **Full period, prob=128:** WIDTH=8, CHANNELS=2, seed=0xA5, len=0, prob0=prob1=128, en=1 → 255 bit_valid cycles, 128 ones per channel, done on the 255th. lfsr_state returns to 0xA5 after the run and visits 255 distinct values.
- **Probability extremes:** prob0=0, prob1=255, len=0 → channel 0 all zeros, channel 1 all ones across 255 bits.
- **Zero seed:** seed=0 with reset → lfsr_state=0x01. With start, len=0, prob=200 → the stream completes with 200 ones; no lockup.
- **Short length with stall:** len=10, en toggled 1,0,0,1,... → exactly 10 bit_valid pulses and done on the 10th. The bit sequence is identical to the unstalled run.
- **Reset mid-stream:** reset asserted at bit 37 → all outputs 0 immediately and lfsr_state=seed'. After release, start produces the same sequence as the first run.
- **Start ignored in RUN:** start pulsed in RUN with different prob/len → no effect on the current stream. Start in the done cycle → a new stream begins after a one-cycle bit_valid gap.
